// File: rtl/bram_preload_ctl_if.sv
// Preload write stream and PL_* RAM bus between bram_preload_ctl (master) and the RAM array side (slave).
interface bram_preload_ctl_if;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_data;
    logic        PL_INIT;
    logic        PL_ENA;
    logic        PL_WEN;
    logic        PL_REN;
    logic [31:0] PL_ADDR;
    logic [17:0] PL_DATA_IN;
    logic [17:0] PL_DATA_OUT;

    modport master (
        input  s_valid, s_data, PL_DATA_OUT,
        output s_ready, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN
    );

    modport slave (
        output s_valid, s_data, PL_DATA_OUT,
        input  s_ready, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN
    );
endinterface

// File: rtl/bram_preload_ctl.sv
// Preload bus master: streams words into one RAM (or all, by broadcast) over PL_*.
// Define BRAM_PRELOAD_VERIFY_EN to build the readback checksum pass and err.
//
// state  | meaning
// IDLE   | waiting for start; cfg latched when it arrives
// WRITE  | accepting stream words, one PL_WEN strobe per handshake
// VERIFY | reading back 0..N-1 and summing PL_DATA_OUT (BRAM_PRELOAD_VERIFY_EN only)
// FIN    | drop enables, pulse done
module bram_preload_ctl #(
    parameter int DEPTH     = 1024,
    parameter int IDX_WIDTH = 10
) (
    input  logic                      PL_CLK,
    input  logic                      PL_RST_n,
    input  logic                      start,
    input  logic [15:0]               cfg_ram_id,
    input  logic [10:0]               cfg_words,
    input  logic                      cfg_bcast,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    bram_preload_ctl_if.master        pl
);

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);
    localparam int          PAD_W   = 15 - IDX_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FIN} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            id_q, id_d;
    logic                   bcast_q, bcast_d;
    logic [10:0]            n_q, n_d;
    logic [10:0]            idx_q, idx_d;
    logic [17:0]            wsum_q, wsum_d;
    logic                   s_ready_q, s_ready_d;
    logic                   init_q, init_d;
    logic                   ena_q, ena_d;
    logic                   wen_q, wen_d;
    logic [IDX_WIDTH-1:0]   addr_idx_q, addr_idx_d;
    logic [17:0]            data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [10:0]            n_clamp;

    assign n_clamp = (cfg_words > DEPTH_W) ? DEPTH_W : cfg_words;

`ifdef BRAM_PRELOAD_VERIFY_EN
    logic                   ren_q, ren_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [10:0]            rcnt_q, rcnt_d;
    logic [17:0]            rsum_q, rsum_d;
    logic                   err_q, err_d;
`endif

    always_ff @(posedge PL_CLK or negedge PL_RST_n) begin
        if (!PL_RST_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            bcast_q    <= 1'b0;
            n_q        <= '0;
            idx_q      <= '0;
            wsum_q     <= '0;
            s_ready_q  <= 1'b0;
            init_q     <= 1'b0;
            ena_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_idx_q <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BRAM_PRELOAD_VERIFY_EN
            ren_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rcnt_q     <= '0;
            rsum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            bcast_q    <= bcast_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            wsum_q     <= wsum_d;
            s_ready_q  <= s_ready_d;
            init_q     <= init_d;
            ena_q      <= ena_d;
            wen_q      <= wen_d;
            addr_idx_q <= addr_idx_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BRAM_PRELOAD_VERIFY_EN
            ren_q      <= ren_d;
            rd_pend_q  <= rd_pend_d;
            rcnt_q     <= rcnt_d;
            rsum_q     <= rsum_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        bcast_d    = bcast_q;
        n_d        = n_q;
        idx_d      = idx_q;
        wsum_d     = wsum_q;
        s_ready_d  = s_ready_q;
        init_d     = init_q;
        ena_d      = ena_q;
        wen_d      = 1'b0;
        addr_idx_d = addr_idx_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef BRAM_PRELOAD_VERIFY_EN
        ren_d      = 1'b0;
        rd_pend_d  = ren_q;
        rcnt_d     = rcnt_q;
        rsum_d     = rsum_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                // done_q still high means FIN was the previous cycle; that start is dropped
                if (start && !done_q) begin
                    id_d    = cfg_ram_id;
                    bcast_d = cfg_bcast;
                    n_d     = n_clamp;
                    idx_d   = '0;
                    wsum_d  = '0;
                    busy_d  = 1'b1;
`ifdef BRAM_PRELOAD_VERIFY_EN
                    rcnt_d  = '0;
                    rsum_d  = '0;
                    err_d   = 1'b0;
`endif
                    if (n_clamp == 11'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d   = WRITE;
                        s_ready_d = 1'b1;
                        ena_d     = 1'b1;
                        init_d    = cfg_bcast;
                    end
                end
            end
            WRITE: begin
                if (pl.s_valid && s_ready_q) begin
                    wen_d      = 1'b1;
                    addr_idx_d = idx_q[IDX_WIDTH-1:0];
                    data_d     = pl.s_data;
                    idx_d      = idx_q + 11'd1;
                    wsum_d     = wsum_q + pl.s_data;
                    if (idx_q == n_q - 11'd1) begin
                        s_ready_d = 1'b0;
                        idx_d     = '0;
`ifdef BRAM_PRELOAD_VERIFY_EN
                        state_d   = VERIFY;
`else
                        state_d   = FIN;
`endif
                    end
                end
            end
`ifdef BRAM_PRELOAD_VERIFY_EN
            VERIFY: begin
                if (idx_q != n_q) begin
                    ren_d      = 1'b1;
                    addr_idx_d = idx_q[IDX_WIDTH-1:0];
                    idx_d      = idx_q + 11'd1;
                end
                // rd_pend_q marks the cycle the RAM's registered read data is on PL_DATA_OUT
                if (rd_pend_q) begin
                    rsum_d = rsum_q + pl.PL_DATA_OUT;
                    rcnt_d = rcnt_q + 11'd1;
                    if (rcnt_q == n_q - 11'd1) begin
                        err_d   = ((rsum_q + pl.PL_DATA_OUT) != wsum_q);
                        state_d = FIN;
                    end
                end
            end
`endif
            FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                s_ready_d = 1'b0;
                ena_d     = 1'b0;
                init_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pl.s_ready    = s_ready_q;
    assign pl.PL_INIT    = init_q;
    assign pl.PL_ENA     = ena_q;
    assign pl.PL_WEN     = wen_q;
    assign pl.PL_ADDR    = {id_q, {PAD_W{1'b0}}, addr_idx_q, 1'b0};
    assign pl.PL_DATA_IN = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef BRAM_PRELOAD_VERIFY_EN
    assign pl.PL_REN = ren_q;
    assign err       = err_q;
`else
    logic unused_dout;
    assign unused_dout = ^pl.PL_DATA_OUT;
    assign pl.PL_REN   = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_bram_preload_ctl.sv
// Directed and randomized sessions for bram_preload_ctl against a word-level model and a behavioural RAM.
module tb_bram_preload_ctl;

`ifdef BRAM_PRELOAD_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic        PL_CLK     = 1'b0;
    logic        PL_RST_n   = 1'b0;
    logic        start      = 1'b0;
    logic [15:0] cfg_ram_id = '0;
    logic [10:0] cfg_words  = '0;
    logic        cfg_bcast  = 1'b0;
    logic        busy, done, err;

    bram_preload_ctl_if bus ();

    bram_preload_ctl #(.DEPTH(1024), .IDX_WIDTH(10)) dut (
        .PL_CLK     (PL_CLK),
        .PL_RST_n   (PL_RST_n),
        .start      (start),
        .cfg_ram_id (cfg_ram_id),
        .cfg_words  (cfg_words),
        .cfg_bcast  (cfg_bcast),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pl         (bus)
    );

    always #5 PL_CLK = ~PL_CLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] ram  [0:1023];
    logic [17:0] stim [0:1023];
    logic [17:0] ram_dout    = '0;
    logic        corrupt_en  = 1'b0;
    logic [9:0]  corrupt_idx = '0;
    logic [17:0] corrupt_val = '0;
    logic [31:0] last_addr;
    logic [7:0]  wen_hist;
    int          hist_len;

    assign bus.PL_DATA_OUT = ram_dout;

    // behavioural RAM: synchronous write and synchronous read, one clock latency
    always @(posedge PL_CLK) begin
        if (bus.PL_ENA && bus.PL_WEN)
            ram[bus.PL_ADDR[10:1]] <= bus.PL_DATA_IN;
        if (bus.PL_REN)
            ram_dout <= (corrupt_en && bus.PL_ADDR[10:1] == corrupt_idx) ? corrupt_val
                                                                         : ram[bus.PL_ADDR[10:1]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outputs_flat();
        return {6'b0, bus.s_ready, bus.PL_INIT, bus.PL_ENA, bus.PL_WEN, bus.PL_REN,
                bus.PL_ADDR, bus.PL_DATA_IN, busy, done, err};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) stim[i] = 18'($urandom);
    endtask

    task automatic run_session(input string tag, input logic [15:0] id, input logic [10:0] words,
                               input logic bcast, input int vmode);
        int n_exp, cyc, hs, wr, rd, step, done_cyc, done_cnt, last_hs, exp_done;
        logic hs_pend, ok_wen, ok_wr, ok_ctl, ok_rdy, ok_rd, ok_mem, exp_err;
        logic [17:0] wsum, rsum, rv;

        n_exp = (words > 11'd1024) ? 1024 : int'(words);
        @(negedge PL_CLK);
        cfg_ram_id = id; cfg_words = words; cfg_bcast = bcast; start = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = stim[0];
        @(negedge PL_CLK);
        start = 1'b0;
        cfg_ram_id = 16'($urandom); cfg_words = 11'($urandom); cfg_bcast = ~bcast;
        cyc = 1; hs = 0; wr = 0; rd = 0; step = 0; done_cyc = -1; done_cnt = 0; last_hs = 0;
        hs_pend = 1'b0; ok_wen = 1'b1; ok_wr = 1'b1; ok_ctl = 1'b1; ok_rdy = 1'b1; ok_rd = 1'b1;
        hist_len = 0; wen_hist = '0; last_addr = '0;
        while (cyc < 2 * n_exp + 40) begin
            if (bus.PL_WEN !== hs_pend) ok_wen = 1'b0;
            if (bus.PL_WEN === 1'b1) begin
                if (bus.PL_ADDR !== {id, 5'b0, wr[9:0], 1'b0} || bus.PL_DATA_IN !== stim[wr % 1024])
                    ok_wr = 1'b0;
                last_addr = bus.PL_ADDR;
                wr++;
                if (wr == n_exp && bus.s_ready !== 1'b0) ok_rdy = 1'b0;
            end
            if (bus.PL_REN === 1'b1) begin
                if (bus.PL_ADDR !== {id, 5'b0, rd[9:0], 1'b0} || bus.PL_WEN !== 1'b0) ok_rd = 1'b0;
                rd++;
            end
            if ((hist_len > 0 || bus.PL_WEN === 1'b1) && hist_len < 8) begin
                wen_hist = {wen_hist[6:0], bus.PL_WEN};
                hist_len++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0) begin
                if (busy !== 1'b1 || bus.PL_ENA !== ((n_exp > 0) ? 1'b1 : 1'b0) ||
                    bus.PL_INIT !== ((n_exp > 0) ? bcast : 1'b0))
                    ok_ctl = 1'b0;
            end else if (busy !== 1'b0 || bus.PL_ENA !== 1'b0 || bus.PL_INIT !== 1'b0 ||
                         bus.s_ready !== 1'b0 || bus.PL_REN !== 1'b0) begin
                ok_ctl = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            bus.s_data = stim[hs % 1024];
            case (vmode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (step % 2 == 0);
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            step++;
            hs_pend = bus.s_valid && bus.s_ready;
            if (hs_pend) begin
                hs++;
                last_hs = cyc;
            end
            @(negedge PL_CLK);
            cyc++;
        end
        bus.s_valid = 1'b0;

        wsum = '0; rsum = '0; ok_mem = 1'b1;
        for (int i = 0; i < n_exp; i++) begin
            wsum += stim[i];
            rv = (corrupt_en && i == int'(corrupt_idx)) ? corrupt_val : stim[i];
            rsum += rv;
            if (ram[i] !== stim[i]) ok_mem = 1'b0;
        end
        exp_err  = VERIFY_ON && (wsum != rsum);
        exp_done = (n_exp == 0) ? 2 : last_hs + 2 + (VERIFY_ON ? n_exp + 2 : 0);

        check({tag, " accepted"},     64'(hs),       64'(n_exp));
        check({tag, " writes"},       64'(wr),       64'(n_exp));
        check({tag, " wen_timing"},   64'(ok_wen),   64'(1));
        check({tag, " wr_addr_data"}, 64'(ok_wr),    64'(1));
        check({tag, " s_ready_drop"}, 64'(ok_rdy),   64'(1));
        check({tag, " ctl_levels"},   64'(ok_ctl),   64'(1));
        check({tag, " done_cycle"},   64'(done_cyc), 64'(exp_done));
        check({tag, " done_pulses"},  64'(done_cnt), 64'(1));
        check({tag, " ram_contents"}, 64'(ok_mem),   64'(1));
        check({tag, " reads"},        64'(rd),       64'(VERIFY_ON ? n_exp : 0));
        check({tag, " read_addr"},    64'(ok_rd),    64'(1));
        check({tag, " err"},          64'(err),      64'(exp_err));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge PL_CLK);
        check("reset outputs", outputs_flat(), 64'(0));
        PL_RST_n = 1'b1;

        for (int i = 0; i < 1024; i++) stim[i] = 18'(i + 1);
        run_session("basic", 16'h0012, 11'd4, 1'b0, 0);
        check("basic wen_pattern", 64'(wen_hist), 64'(8'b1111_0000));
        check("basic last_addr", 64'(last_addr), 64'(32'h0012_0006));

        fill_random();
        run_session("toggle", 16'h0345, 11'd3, 1'b0, 1);
        check("toggle wen_pattern", 64'(wen_hist), 64'(8'b1010_1000));

        run_session("bcast", 16'hBEEF, 11'd2, 1'b1, 0);
        run_session("zero", 16'h0001, 11'd0, 1'b0, 0);
        check("zero wen_pattern", 64'(wen_hist), 64'(0));

        fill_random();
        run_session("clamp", 16'h7A5C, 11'd2047, 1'b0, 0);
        check("clamp last_addr_lo", 64'(last_addr[10:0]), 64'(11'h7FE));

        stim[0] = 18'h3FFFF;
        stim[1] = 18'h00001;
        run_session("verify_ok", 16'h0020, 11'd2, 1'b0, 0);
        corrupt_en = 1'b1; corrupt_idx = 10'd1; corrupt_val = 18'h00002;
        run_session("verify_bad", 16'h0020, 11'd2, 1'b0, 0);
        corrupt_en = 1'b0;
        fill_random();
        run_session("err_clear", 16'h0021, 11'd5, 1'b0, 2);

        @(negedge PL_CLK);
        cfg_ram_id = 16'h5A5A; cfg_words = 11'd10; cfg_bcast = 1'b1; start = 1'b1;
        @(negedge PL_CLK);
        start = 1'b0;
        bus.s_valid = 1'b1;
        repeat (4) @(negedge PL_CLK);
        #2 PL_RST_n = 1'b0;
        #1 check("reset async", outputs_flat(), 64'(0));
        bus.s_valid = 1'b0;
        @(negedge PL_CLK);
        PL_RST_n = 1'b1;
        fill_random();
        run_session("after_reset", 16'h0ACE, 11'd7, 1'b0, 2);

        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_session("rand", 16'($urandom), 11'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
